broadcast_cdb_multi: RTL
========================

Name: broadcast_cdb_multi

Overview:
Next-generation common-data-bus arbiter for the Tomasulo back end.
- Accepts completed results (cdb_t: tag, val) from NUM_RS_STATIONS functional units.
- Buffers each unit's results in a private FIFO.
- Broadcasts up to NUM_CDB results per cycle to the reservation stations and register file, using round-robin fairness.
- Drives per-unit backpressure, so no result is ever lost when more than NUM_CDB units finish in the same cycle.

Parameters:
NUM_RS_STATIONS, 6, number of functional-unit result inputs (≥1)
NUM_CDB, 2, number of broadcast lanes per cycle (1..NUM_RS_STATIONS)
FIFO_DEPTH, 2, entries per unit result FIFO (≥1)

Ports:
clk_i  input  1  clock; all state updates on rising edge
RST_i  input  1  asynchronous, active-high reset
fu_res_i  input  [NUM_RS_STATIONS] x cdb_t  per-unit result; valid when tag != NO_VAL
fu_ready_o  output  [NUM_RS_STATIONS]  unit i may present a result this cycle
broadcast_o  output  [NUM_CDB] x cdb_t  broadcast lanes; idle lane has tag = NO_VAL, val = '0

Behaviour:
Reset:
- RST_i high asynchronously empties all FIFOs and sets rr_ptr = 0.
- While RST_i is high: every broadcast_o lane is tag = NO_VAL, val = '0, and fu_ready_o = all ones.
- Reset asserted mid-operation discards all buffered results.

Enqueue:
- At a rising edge, unit i's result is pushed when fu_res_i[i].tag != NO_VAL and fu_ready_o[i] = 1.
- fu_ready_o[i] = (count[i] < FIFO_DEPTH). It is combinational from registered count only; no same-cycle pop credit.
- A valid result presented while fu_ready_o[i] = 0 is not accepted. The unit must hold it until ready.

Arbitration (combinational on registered FIFO state):
- Scan units rr_ptr, rr_ptr+1, ... mod NUM_RS_STATIONS.
- The first NUM_CDB non-empty FIFOs are granted, in scan order, to lanes 0, 1, ... NUM_CDB-1.
- Unused lanes are idle.
- broadcast_o shows each granted FIFO's head entry and is stable for the whole cycle.
- Each granted FIFO pops at the next rising edge.

Latency:
- A result accepted at edge k appears on broadcast_o in the cycle after edge k (1 cycle) if its FIFO was empty and it wins a grant.
- Otherwise it waits for its turn.
- Per-unit results broadcast in arrival order.

Round-robin pointer:
- If ≥1 grant in a cycle, rr_ptr ← (index of highest-scanned granted unit + 1) mod NUM_RS_STATIONS.
- If there are no grants, rr_ptr is unchanged.
- Wrap-around is required.

Simultaneous push and pop on the same FIFO: count is unchanged and ordering is preserved.

Starvation bound: any non-empty FIFO is granted within ceil(NUM_RS_STATIONS / NUM_CDB) cycles.

FIFO pointers: wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH+1).

Optional Feature:
Macro CDB_STATS_EN.
- Defined:
  - Adds outputs bcast_cnt_o (32-bit) and stall_cnt_o (32-bit), both reset to 0.
  - bcast_cnt_o increments by the number of non-idle lanes each cycle.
  - stall_cnt_o increments by 1 each cycle in which any unit presents a valid tag while its fu_ready_o = 0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: neither port exists, no counter logic is present, and behaviour is otherwise identical.

Test Plan:
1. Reset, then ALU_3 on input 2 for one cycle → lane 0 = {ALU_3, val}, lane 1 idle, in the cycle after acceptance; all outputs idle the cycle after that.
2. Same-cycle SHIFT_1 (in 4), ALU_1 (in 0), ALU_2 (in 1), NUM_CDB = 2, rr_ptr = 0:
   - Cycle 1: lane0 = ALU_1, lane1 = ALU_2.
   - Cycle 2: lane0 = SHIFT_1.
   - rr_ptr ends at 5.
3. Backpressure, FIFO_DEPTH = 2: hold input 3 valid 4 consecutive cycles while inputs 0, 1, 2 are also continuously valid → fu_ready_o[3] drops to 0 when count = 2. Every accepted value is broadcast exactly once, in order, with no loss or duplication.
4. All 6 inputs valid every cycle for 12 cycles → each unit is granted once per 3 cycles (6 units / 2 lanes) and lane order follows rr_ptr wrap-around (e.g. 4, 5, then 0, 1).
5. Assert RST_i asynchronously mid-burst with 3 results buffered → broadcast_o is immediately all NO_VAL and fu_ready_o is all 1. After release, no stale result is ever broadcast.
6. With CDB_STATS_EN, scenario 2 plus one refused cycle → bcast_cnt_o = 3, stall_cnt_o = 1.

Source files
------------

// File: rtl/broadcast_cdb_multi.sv
// Common-data-bus arbiter: per-unit result FIFOs drained onto NUM_CDB round-robin broadcast lanes.
// Build with CDB_STATS_EN defined to add the broadcast/stall counters.
package broadcast_cdb_multi_pkg;
  localparam int TAG_W = 4;
  localparam int VAL_W = 32;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] val;
  } cdb_t;

  localparam logic [TAG_W-1:0] NO_VAL  = 4'd0;
  localparam logic [TAG_W-1:0] ALU_1   = 4'd1;
  localparam logic [TAG_W-1:0] ALU_2   = 4'd2;
  localparam logic [TAG_W-1:0] ALU_3   = 4'd3;
  localparam logic [TAG_W-1:0] SHIFT_1 = 4'd4;
  localparam logic [TAG_W-1:0] SHIFT_2 = 4'd5;
  localparam logic [TAG_W-1:0] MUL_1   = 4'd6;
endpackage

// Generic synchronous FIFO with occupancy count; head entry visible combinationally.
// Latency: a push at edge k is at the head after edge k when the FIFO was empty.
// Backpressure: none internally; caller pushes only below DEPTH and pops only when non-empty.
module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_vld,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_vld)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_vld && !pop_vld)      count <= count + CNT_W'(1);
      else if (!push_vld && pop_vld) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Round-robin CDB arbiter: grants the first NUM_CDB non-empty unit FIFOs from rr_ptr onward.
// Latency: one cycle from acceptance to broadcast for an empty FIFO that wins a grant.
// Backpressure: fu_ready_o[i] low while unit i's FIFO is full, no same-cycle pop credit.
module broadcast_cdb_multi
  import broadcast_cdb_multi_pkg::*;
#(
  parameter int NUM_RS_STATIONS = 6,
  parameter int NUM_CDB         = 2,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                       clk_i,
  input  logic                       RST_i,
  input  cdb_t                       fu_res_i [NUM_RS_STATIONS],
  output logic [NUM_RS_STATIONS-1:0] fu_ready_o,
  output cdb_t                       broadcast_o [NUM_CDB]
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]                bcast_cnt_o,
  output logic [31:0]                stall_cnt_o
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = (NUM_RS_STATIONS > 1) ? $clog2(NUM_RS_STATIONS) : 1;

  logic [NUM_RS_STATIONS-1:0] push;
  logic [NUM_RS_STATIONS-1:0] grant;
  logic [CNT_W-1:0]           count [NUM_RS_STATIONS];
  cdb_t                       head  [NUM_RS_STATIONS];
  logic [RR_W-1:0]            rr_ptr;
  int                         lanes_used;
  int                         last_grant;
  int                         scan_idx;

  for (genvar i = 0; i < NUM_RS_STATIONS; i++) begin : g_unit
    assign fu_ready_o[i] = (count[i] < CNT_W'(FIFO_DEPTH));
    assign push[i]       = (fu_res_i[i].tag != NO_VAL) && fu_ready_o[i];

    cdb_fifo #(
      .W     ($bits(cdb_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i    (clk_i),
      .rst      (RST_i),
      .push_vld (push[i]),
      .push_dat (fu_res_i[i]),
      .pop_vld  (grant[i]),
      .head_dat (head[i]),
      .count    (count[i])
    );
  end

  // Scan from rr_ptr; lanes fill in scan order, so lane 0 always holds the earliest-scanned winner.
  always_comb begin
    grant      = '0;
    lanes_used = 0;
    last_grant = int'(rr_ptr);
    scan_idx   = 0;
    for (int l = 0; l < NUM_CDB; l++) begin
      broadcast_o[l] = '{tag: NO_VAL, val: '0};
    end
    for (int k = 0; k < NUM_RS_STATIONS; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_RS_STATIONS;
      if ((count[scan_idx] != '0) && (lanes_used < NUM_CDB)) begin
        grant[scan_idx]         = 1'b1;
        broadcast_o[lanes_used] = head[scan_idx];
        lanes_used              = lanes_used + 1;
        last_grant              = scan_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge RST_i) begin
    if (RST_i) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= RR_W'((last_grant + 1) % NUM_RS_STATIONS);
    end
  end

`ifdef CDB_STATS_EN
  logic        stall_any;
  logic [32:0] bcast_sum;

  always_comb begin
    stall_any = 1'b0;
    for (int i = 0; i < NUM_RS_STATIONS; i++) begin
      if ((fu_res_i[i].tag != NO_VAL) && !fu_ready_o[i]) stall_any = 1'b1;
    end
  end

  assign bcast_sum = {1'b0, bcast_cnt_o} + 33'(lanes_used);

  always_ff @(posedge clk_i or posedge RST_i) begin
    if (RST_i) begin
      bcast_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      bcast_cnt_o <= bcast_sum[32] ? 32'hFFFF_FFFF : bcast_sum[31:0];
      if (stall_any && (stall_cnt_o != 32'hFFFF_FFFF)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif
endmodule
